// File: rtl/pipe_stage_reg.sv
`timescale 1ns/1ps
// Elastic pipeline register: STAGES slots of {ctrl,data}, STAGES-cycle latency, one entry per cycle.
// A stall only backs up through full slots; empty slots always accept, so bubbles collapse.
module pipe_stage_reg #(
  parameter int CW     = 3,
  parameter int DW     = 101,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_ctrl,
  input  logic [DW-1:0]    in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ctrl,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("pipe_stage_reg: STAGES must be in 1..4");
  end

  logic [STAGES-1:0] v_q, v_d, adv, src_v;
  logic [CW-1:0]     c_q   [STAGES];
  logic [CW-1:0]     c_d   [STAGES];
  logic [CW-1:0]     src_c [STAGES];
  logic [DW-1:0]     d_q   [STAGES];
  logic [DW-1:0]     d_d   [STAGES];
  logic [DW-1:0]     src_d [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_xfer;

  for (genvar i = 0; i < STAGES; i++) begin : g_src
    if (i == 0) begin : g_head
      assign src_v[i] = in_valid;
      assign src_c[i] = in_ctrl;
      assign src_d[i] = in_data;
    end else begin : g_link
      assign src_v[i] = v_q[i-1];
      assign src_c[i] = c_q[i-1];
      assign src_d[i] = d_q[i-1];
    end
  end

  // A slot may load when it is empty or when the slot after it is moving.
  always_comb begin : adv_chain
    logic a;
    a = !v_q[LAST] | out_ready;
    adv = '0;
    adv[LAST] = a;
    for (int i = LAST - 1; i >= 0; i--) begin
      a = !v_q[i] | a;
      adv[i] = a;
    end
  end

  always_comb begin
    v_d = v_q;
    c_d = c_q;
    d_d = d_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush) begin
        v_d[i] = 1'b0;
        c_d[i] = '0;
      end else if (adv[i]) begin
        v_d[i] = src_v[i];
        c_d[i] = src_v[i] ? src_c[i] : '0;
        d_d[i] = src_d[i];
      end
    end
  end

  // The departing entry still counts when flush lands on the same edge.
  assign out_xfer = v_q[LAST] & out_ready;
  assign cnt_d    = (out_xfer && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        c_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[LAST];
  assign out_ctrl  = v_q[LAST] ? c_q[LAST] : '0;
  assign out_data  = d_q[LAST];
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
`timescale 1ns/1ps
// Directed bench for pipe_stage_reg: a 1-slot table run plus hand sequences on 3-slot and 4-bit-counter instances.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // u1: STAGES=1
  logic iv1, ir1, fl1, ov1, or1;
  logic [2:0] ic1, oc1;
  logic [7:0] id1, od1;
  logic [15:0] cnt1;
  // u3: STAGES=3
  logic iv3, ir3, fl3, ov3, or3;
  logic [2:0] ic3, oc3;
  logic [7:0] id3, od3;
  logic [15:0] cnt3;
  // uc: STAGES=1, CNT_W=4
  logic ivc, irc, flc, ovc, orc;
  logic [2:0] icc, occ;
  logic [7:0] idc, odc;
  logic [3:0] cntc;

  pipe_stage_reg #(.CW(3), .DW(8), .STAGES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1), .in_data(id1),
    .flush(fl1), .out_valid(ov1), .out_ready(or1), .out_ctrl(oc1), .out_data(od1), .xfer_cnt(cnt1));

  pipe_stage_reg #(.CW(3), .DW(8), .STAGES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_ctrl(ic3), .in_data(id3),
    .flush(fl3), .out_valid(ov3), .out_ready(or3), .out_ctrl(oc3), .out_data(od3), .xfer_cnt(cnt3));

  pipe_stage_reg #(.CW(3), .DW(8), .STAGES(1), .CNT_W(4)) uc (
    .clk(clk), .rst(rst), .in_valid(ivc), .in_ready(irc), .in_ctrl(icc), .in_data(idc),
    .flush(flc), .out_valid(ovc), .out_ready(orc), .out_ctrl(occ), .out_data(odc), .xfer_cnt(cntc));

  typedef struct {
    logic        iv;
    logic [2:0]  c;
    logic [7:0]  d;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [2:0]  e_oc;
    logic [7:0]  e_od;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drv3(input logic iv, input logic [2:0] c, input logic [7:0] d,
                      input logic ordy, input logic fl);
    iv3 = iv; ic3 = c; id3 = d; or3 = ordy; fl3 = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    iv1 = 1'b0; ic1 = '0; id1 = '0; fl1 = 1'b0; or1 = 1'b0;
    iv3 = 1'b0; ic3 = '0; id3 = '0; fl3 = 1'b0; or3 = 1'b0;
    ivc = 1'b0; icc = '0; idc = '0; flc = 1'b0; orc = 1'b0;

    //            iv    c     d      ordy  fl    e_ir  e_ov  e_oc  e_od   e_cnt
    tbl[0]  = '{1'b1, 3'd5, 8'd5,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0,  16'd0};
    tbl[1]  = '{1'b1, 3'd5, 8'd6,  1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'd5,  16'd0};
    tbl[2]  = '{1'b1, 3'd5, 8'd7,  1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'd6,  16'd1};
    tbl[3]  = '{1'b0, 3'd0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'd7,  16'd2};
    tbl[4]  = '{1'b0, 3'd0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0,  16'd3};
    tbl[5]  = '{1'b1, 3'd3, 8'd8,  1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0,  16'd3};
    tbl[6]  = '{1'b1, 3'd3, 8'd9,  1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'd8,  16'd3};
    tbl[7]  = '{1'b1, 3'd3, 8'd9,  1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 8'd8,  16'd3};
    tbl[8]  = '{1'b0, 3'd0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0,  16'd3};
    tbl[9]  = '{1'b1, 3'd1, 8'd10, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0,  16'd3};
    tbl[10] = '{1'b1, 3'd1, 8'd11, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 8'd10, 16'd3};
    tbl[11] = '{1'b0, 3'd0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0,  16'd4};

    // reset state
    @(negedge clk);
    chk("rst.u1.out_valid", 32'(ov1), 32'd0);
    chk("rst.u1.out_ctrl",  32'(oc1), 32'd0);
    chk("rst.u1.out_data",  32'(od1), 32'd0);
    chk("rst.u1.xfer_cnt",  32'(cnt1), 32'd0);
    chk("rst.u3.out_valid", 32'(ov3), 32'd0);
    chk("rst.uc.xfer_cnt",  32'(cntc), 32'd0);
    #2 rst = 1'b0;

    // 1-slot table: streaming, stall, flush while stalled, flush alongside a transfer
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      iv1 = tbl[k].iv; ic1 = tbl[k].c; id1 = tbl[k].d; or1 = tbl[k].ordy; fl1 = tbl[k].fl;
      #1;
      chk($sformatf("t1[%0d].in_ready", k),  32'(ir1),  32'(tbl[k].e_ir));
      chk($sformatf("t1[%0d].out_valid", k), 32'(ov1),  32'(tbl[k].e_ov));
      chk($sformatf("t1[%0d].out_ctrl", k),  32'(oc1),  32'(tbl[k].e_oc));
      chk($sformatf("t1[%0d].xfer_cnt", k),  32'(cnt1), 32'(tbl[k].e_cnt));
      if (tbl[k].e_ov)
        chk($sformatf("t1[%0d].out_data", k), 32'(od1), 32'(tbl[k].e_od));
    end
    @(negedge clk);
    iv1 = 1'b0; fl1 = 1'b0;

    // 3 slots: fill A,B,C under stall, then drain in order
    drv3(1'b1, 3'b101, 8'hA1, 1'b0, 1'b0);
    @(negedge clk); drv3(1'b1, 3'b101, 8'hB2, 1'b0, 1'b0);
    @(negedge clk); drv3(1'b1, 3'b101, 8'hC3, 1'b0, 1'b0);
    @(negedge clk); drv3(1'b1, 3'b101, 8'hD4, 1'b0, 1'b0);
    #1;
    chk("t2.full.in_ready",  32'(ir3), 32'd0);
    chk("t2.full.out_valid", 32'(ov3), 32'd1);
    chk("t2.full.out_data",  32'(od3), 32'hA1);
    @(negedge clk); #1;
    chk("t2.hold.in_ready",  32'(ir3), 32'd0);
    chk("t2.hold.out_data",  32'(od3), 32'hA1);
    @(negedge clk); drv3(1'b0, 3'b000, 8'h00, 1'b1, 1'b0); #1;
    chk("t2.drain0.out_data", 32'(od3), 32'hA1);
    chk("t2.drain0.out_ctrl", 32'(oc3), 32'd5);
    @(negedge clk); #1;
    chk("t2.drain1.out_valid", 32'(ov3), 32'd1);
    chk("t2.drain1.out_data",  32'(od3), 32'hB2);
    @(negedge clk); #1;
    chk("t2.drain2.out_valid", 32'(ov3), 32'd1);
    chk("t2.drain2.out_data",  32'(od3), 32'hC3);
    @(negedge clk); #1;
    chk("t2.empty.out_valid", 32'(ov3), 32'd0);
    chk("t2.empty.xfer_cnt",  32'(cnt3), 32'd3);

    // 3 slots: only the last slot full and stalled, a new entry still enters and collapses forward
    @(negedge clk); drv3(1'b1, 3'b110, 8'hE0, 1'b0, 1'b0);
    @(negedge clk); drv3(1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); drv3(1'b1, 3'b011, 8'hF0, 1'b0, 1'b0); #1;
    chk("t3.bubble.in_ready",  32'(ir3), 32'd1);
    chk("t3.bubble.out_valid", 32'(ov3), 32'd1);
    chk("t3.bubble.out_data",  32'(od3), 32'hE0);
    chk("t3.bubble.out_ctrl",  32'(oc3), 32'd6);
    @(negedge clk); drv3(1'b0, 3'b000, 8'h00, 1'b0, 1'b0); #1;
    chk("t3.stall.in_ready", 32'(ir3), 32'd1);
    chk("t3.stall.out_data", 32'(od3), 32'hE0);
    @(negedge clk); drv3(1'b0, 3'b000, 8'h00, 1'b1, 1'b0); #1;
    chk("t3.out0.out_data", 32'(od3), 32'hE0);
    @(negedge clk); #1;
    chk("t3.out1.out_valid", 32'(ov3), 32'd1);
    chk("t3.out1.out_data",  32'(od3), 32'hF0);
    chk("t3.out1.out_ctrl",  32'(oc3), 32'd3);
    @(negedge clk); #1;
    chk("t3.empty.out_valid", 32'(ov3), 32'd0);
    chk("t3.empty.out_ctrl",  32'(oc3), 32'd0);
    chk("t3.empty.xfer_cnt",  32'(cnt3), 32'd5);

    // 3 slots: flush two held entries while a new one is offered
    @(negedge clk); drv3(1'b1, 3'b111, 8'h47, 1'b0, 1'b0);
    @(negedge clk); drv3(1'b1, 3'b001, 8'h48, 1'b0, 1'b0);
    @(negedge clk); drv3(1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drv3(1'b1, 3'b111, 8'h4A, 1'b0, 1'b1); #1;
    chk("t4.pre.out_valid", 32'(ov3), 32'd1);
    chk("t4.pre.out_data",  32'(od3), 32'h47);
    chk("t4.pre.in_ready",  32'(ir3), 32'd1);
    @(negedge clk); drv3(1'b0, 3'b000, 8'h00, 1'b1, 1'b0); #1;
    chk("t4.post.out_valid", 32'(ov3), 32'd0);
    chk("t4.post.out_ctrl",  32'(oc3), 32'd0);
    chk("t4.post.xfer_cnt",  32'(cnt3), 32'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t4.after%0d.out_valid", k), 32'(ov3), 32'd0);
    end
    chk("t4.end.xfer_cnt", 32'(cnt3), 32'd5);

    // 4-bit counter saturates at 15 after 20 transfers
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ivc = 1'b1; icc = 3'b010; idc = 8'(k); orc = 1'b1; flc = 1'b0;
      #1;
      if (k == 10) chk("t5.k10.xfer_cnt", 32'(cntc), 32'd9);
      if (k == 16) begin
        chk("t5.k16.xfer_cnt",  32'(cntc), 32'd15);
        chk("t5.k16.out_data",  32'(odc), 32'd15);
        chk("t5.k16.out_ctrl",  32'(occ), 32'd2);
        chk("t5.k16.out_valid", 32'(ovc), 32'd1);
        chk("t5.k16.in_ready",  32'(irc), 32'd1);
      end
      if (k == 17) chk("t5.k17.xfer_cnt", 32'(cntc), 32'd15);
    end
    @(negedge clk); ivc = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5.end.xfer_cnt",  32'(cntc), 32'd15);
    chk("t5.end.out_valid", 32'(ovc), 32'd0);

    // async reset mid-stream, then refill
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drv3(1'b1, 3'b100, 8'(8'h30 + k), 1'b1, 1'b0);
    end
    @(negedge clk); drv3(1'b1, 3'b100, 8'h34, 1'b1, 1'b0); #1;
    chk("t6.pre.out_valid", 32'(ov3), 32'd1);
    chk("t6.pre.out_data",  32'(od3), 32'h31);
    chk("t6.pre.xfer_cnt",  32'(cnt3), 32'd6);
    #2 rst = 1'b1;
    #1;
    chk("t6.rst.out_valid", 32'(ov3), 32'd0);
    chk("t6.rst.out_ctrl",  32'(oc3), 32'd0);
    chk("t6.rst.out_data",  32'(od3), 32'd0);
    chk("t6.rst.xfer_cnt",  32'(cnt3), 32'd0);
    chk("t6.rst.uc_cnt",    32'(cntc), 32'd0);
    drv3(1'b0, 3'b000, 8'h00, 1'b1, 1'b0);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); drv3(1'b1, 3'b010, 8'h5B, 1'b1, 1'b0); #1;
    chk("t6.refill0.out_valid", 32'(ov3), 32'd0);
    @(negedge clk); drv3(1'b0, 3'b000, 8'h00, 1'b1, 1'b0); #1;
    chk("t6.refill1.out_valid", 32'(ov3), 32'd0);
    @(negedge clk); #1;
    chk("t6.refill2.out_valid", 32'(ov3), 32'd0);
    @(negedge clk); #1;
    chk("t6.refill3.out_valid", 32'(ov3), 32'd1);
    chk("t6.refill3.out_data",  32'(od3), 32'h5B);
    chk("t6.refill3.out_ctrl",  32'(oc3), 32'd2);
    @(negedge clk); #1;
    chk("t6.refill4.out_valid", 32'(ov3), 32'd0);
    chk("t6.refill4.xfer_cnt",  32'(cnt3), 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
